// File: rtl/snes_pkg.sv
// Shared definitions for the SNES pad sequencer: FSM state encoding, button
// bit positions and the key codes also consumed by keyboard_decoder.
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_ENCODE   = 3'd4
    } snes_state_t;

    localparam int NUM_BUTTONS = 12;

    // Bit positions within the button word, in pad shift order.
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam logic [7:0] KEY_NONE   = 8'd0;
    localparam logic [7:0] KEY_B      = 8'd1;
    localparam logic [7:0] KEY_Y      = 8'd2;
    localparam logic [7:0] KEY_SELECT = 8'd3;
    localparam logic [7:0] KEY_START  = 8'd4;
    localparam logic [7:0] KEY_UP     = 8'd5;
    localparam logic [7:0] KEY_DOWN   = 8'd6;
    localparam logic [7:0] KEY_LEFT   = 8'd7;
    localparam logic [7:0] KEY_RIGHT  = 8'd8;
    localparam logic [7:0] KEY_A      = 8'd9;
    localparam logic [7:0] KEY_X      = 8'd10;
    localparam logic [7:0] KEY_L      = 8'd11;
    localparam logic [7:0] KEY_R      = 8'd12;

endpackage

// File: rtl/snes_key_encoder.sv
// Combinational lowest-index priority encoder: active-high button word to key
// code. B has the highest priority; no button pressed gives KEY_NONE.
module snes_key_encoder
    import snes_pkg::*;
(
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [7:0]             key_code
);

    always_comb begin
        key_code = KEY_NONE;
        if      (buttons[BTN_B])      key_code = KEY_B;
        else if (buttons[BTN_Y])      key_code = KEY_Y;
        else if (buttons[BTN_SELECT]) key_code = KEY_SELECT;
        else if (buttons[BTN_START])  key_code = KEY_START;
        else if (buttons[BTN_UP])     key_code = KEY_UP;
        else if (buttons[BTN_DOWN])   key_code = KEY_DOWN;
        else if (buttons[BTN_LEFT])   key_code = KEY_LEFT;
        else if (buttons[BTN_RIGHT])  key_code = KEY_RIGHT;
        else if (buttons[BTN_A])      key_code = KEY_A;
        else if (buttons[BTN_X])      key_code = KEY_X;
        else if (buttons[BTN_L])      key_code = KEY_L;
        else if (buttons[BTN_R])      key_code = KEY_R;
    end

endmodule

// File: rtl/snes_pad_sequencer.sv
// Serial SNES pad poller: drives latch/clock, shifts in 16 bits, keeps the low
// 12 as button state and strobes an encoded key code. SNES_KEY_REPEAT_EN adds auto-repeat.
module snes_pad_sequencer
    import snes_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   poll_req,
    input  logic                   pad_data,
    output logic                   pad_latch,
    output logic                   pad_clk,
    output logic                   busy,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic [7:0]             key_code,
    output logic                   key_strobe
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int TMR_W = $clog2(POLL_PERIOD);

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] POLL_LAST  = TMR_W'(POLL_PERIOD - 1);

    snes_state_t            state_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [TMR_W-1:0]       timer_reg;
    logic [3:0]             bit_reg;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [NUM_BUTTONS-1:0] shift_next;
    logic                   sample;
    logic [NUM_BUTTONS-1:0] new_buttons;
    logic [7:0]             new_code;
    logic                   strobe_cond;

    // The pad presents a bit at the end of the latch pulse and after each
    // rising pad clock; sample at the last cycle of those phases.
    assign sample = ((state_reg == ST_LATCH)    && (div_reg == LATCH_LAST)) ||
                    ((state_reg == ST_SHIFT_HI) && (div_reg == HALF_LAST));

    // Bits 12..15 match no storage slot, so the trailing pad bits drop out.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_shift
            assign shift_next[gi] = (sample && (bit_reg == 4'(gi))) ? pad_data : shift_reg[gi];
        end
    endgenerate

    assign new_buttons = ~shift_reg;

    snes_key_encoder u_encoder (
        .buttons  (new_buttons),
        .key_code (new_code)
    );

`ifdef SNES_KEY_REPEAT_EN
    assign strobe_cond = (new_code != key_code) || (new_code != KEY_NONE);
`else
    assign strobe_cond = (new_code != key_code);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            div_reg    <= '0;
            timer_reg  <= '0;
            bit_reg    <= 4'd0;
            shift_reg  <= '1;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            busy       <= 1'b0;
            buttons    <= '0;
            key_code   <= KEY_NONE;
            key_strobe <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            key_strobe <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (poll_req || (timer_reg == POLL_LAST)) begin
                        state_reg <= ST_LATCH;
                        timer_reg <= '0;
                        div_reg   <= '0;
                        bit_reg   <= 4'd0;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (div_reg == LATCH_LAST) begin
                        state_reg <= ST_SHIFT_LO;
                        div_reg   <= '0;
                        bit_reg   <= 4'd1;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_reg == HALF_LAST) begin
                        state_reg <= ST_SHIFT_HI;
                        div_reg   <= '0;
                        pad_clk   <= 1'b1;
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_reg == HALF_LAST) begin
                        div_reg <= '0;
                        if (bit_reg == 4'd15) begin
                            state_reg <= ST_ENCODE;
                        end else begin
                            state_reg <= ST_SHIFT_LO;
                            bit_reg   <= bit_reg + 4'd1;
                            pad_clk   <= 1'b0;
                        end
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                ST_ENCODE: begin
                    buttons    <= new_buttons;
                    key_code   <= new_code;
                    key_strobe <= strobe_cond;
                    busy       <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snes_pad_sequencer.sv
// Directed bench for snes_pad_sequencer with CLK_DIV=2, POLL_PERIOD=16 and a
// behavioural pad that shifts on latch and on each rising pad clock.
module tb_snes_pad_sequencer;

    localparam int CLK_DIV     = 2;
    localparam int POLL_PERIOD = 16;
    localparam int POLL_LEN    = 32 * CLK_DIV + 1;
    localparam int AUTO_PERIOD = POLL_LEN + POLL_PERIOD;

`ifdef SNES_KEY_REPEAT_EN
    localparam logic REPEAT = 1'b1;
`else
    localparam logic REPEAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        poll_req;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic        busy;
    logic [11:0] buttons;
    logic [7:0]  key_code;
    logic        key_strobe;

    logic [15:0] pad_buttons;
    int          pad_idx;
    int          cyc;
    int          strobe_cnt;
    int          n_checks;
    int          n_fail;

    snes_pad_sequencer #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .poll_req   (poll_req),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .busy       (busy),
        .buttons    (buttons),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: pressed buttons read as 0.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_idx <= 0;
        else           pad_idx <= pad_idx + 1;
    end
    assign pad_data = (pad_idx < 16) ? ~pad_buttons[pad_idx[3:0]] : 1'b1;

    initial begin
        cyc        = 0;
        strobe_cnt = 0;
        pad_idx    = 0;
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic start_poll(input logic [15:0] mask, output int t0);
        pad_buttons = mask;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        t0 = cyc;
        check("latch_rise", {31'd0, pad_latch}, 32'd1);
    endtask

    task automatic finish_poll(input int t0, input logic [11:0] eb, input logic [7:0] ec, input logic es);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check("busy_done", {31'd0, done}, 32'd1);
        check("latency", cyc - t0, POLL_LEN);
        check("buttons", {20'd0, buttons}, {20'd0, eb});
        check("key_code", {24'd0, key_code}, {24'd0, ec});
        check("strobe", {31'd0, key_strobe}, {31'd0, es});
        @(negedge clk);
        check("strobe_off", {31'd0, key_strobe}, 32'd0);
    endtask

    task automatic wait_latch(output int t);
        logic prev;
        logic found;
        prev  = pad_latch;
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pad_latch && !prev) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
            prev = pad_latch;
        end
        check("latch_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, s0;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        poll_req    = 1'b0;
        pad_buttons = 16'h0000;

        // Reset values visible before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_latch", {31'd0, pad_latch}, 32'd0);
        check("rst_clk", {31'd0, pad_clk}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_buttons", {20'd0, buttons}, 32'd0);
        check("rst_code", {24'd0, key_code}, 32'd0);
        check("rst_strobe", {31'd0, key_strobe}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // No buttons: code stays 0, no strobe
        start_poll(16'h0000, t0);
        finish_poll(t0, 12'h000, 8'd0, 1'b0);

        // Up only
        start_poll(16'h0010, t0);
        finish_poll(t0, 12'h010, 8'd5, 1'b1);

        // Left + A, plus pressed trailing bits that must be discarded
        start_poll(16'hF140, t0);
        finish_poll(t0, 12'h140, 8'd7, 1'b1);

        // Hold Up across three automatic polls
        s0          = strobe_cnt;
        pad_buttons = 16'h0010;
        wait_latch(t1);
        wait_latch(t2);
        check("auto_period1", t2 - t1, AUTO_PERIOD);
        wait_latch(t3);
        check("auto_period2", t3 - t2, AUTO_PERIOD);
        finish_poll(t3, 12'h010, 8'd5, REPEAT);
        check("hold_strobes", strobe_cnt - s0, REPEAT ? 32'd3 : 32'd1);

        // Release
        start_poll(16'h0000, t0);
        finish_poll(t0, 12'h000, 8'd0, 1'b1);

        // poll_req during SHIFT_HI is ignored
        start_poll(16'h0010, t0);
        repeat (6) @(negedge clk);
        check("in_shift_hi", {31'd0, pad_clk}, 32'd1);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        finish_poll(t0, 12'h010, 8'd5, 1'b1);
        wait_latch(t1);
        check("req_ignored", t1 - t0, AUTO_PERIOD);

        // Reset during SHIFT_LO
        repeat (4) @(negedge clk);
        check("in_shift_lo", {31'd0, pad_clk}, 32'd0);
        s0    = strobe_cnt;
        reset = 1'b1;
        #1;
        check("mid_rst_clk", {31'd0, pad_clk}, 32'd1);
        check("mid_rst_latch", {31'd0, pad_latch}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_code", {24'd0, key_code}, 32'd0);
        check("mid_rst_buttons", {20'd0, buttons}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_nostrobe", strobe_cnt - s0, 32'd0);
        check("mid_rst_code_hold", {24'd0, key_code}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
